// File: rtl/id_ex_if.sv
// Bundle between the ID/EX stage and its neighbours: decoded ID fields, forward
// sources from EX/MEM and MEM/WB, and the operands/controls handed to EX.
interface id_ex_if #(
  parameter int XLEN = 32
);
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i;
  logic [XLEN-1:0] id_rd1_i;
  logic [XLEN-1:0] id_rd2_i;
  logic [XLEN-1:0] id_imm_i;
  logic [4:0]      id_rs1_i;
  logic [4:0]      id_rs2_i;
  logic [4:0]      id_rd_i;
  logic            id_use_rs1_i;
  logic            id_use_rs2_i;
  logic [4:0]      id_aluop_i;
  logic            id_alusrc_a_i;
  logic            id_alusrc_b_i;
  logic            id_regwrite_i;
  logic            id_memread_i;
  logic            id_memwrite_i;
  logic [1:0]      id_wdsel_i;
  logic            flush_i;
  logic            exmem_regwrite_i;
  logic [4:0]      exmem_rd_i;
  logic [XLEN-1:0] exmem_result_i;
  logic            memwb_regwrite_i;
  logic [4:0]      memwb_rd_i;
  logic [XLEN-1:0] memwb_result_i;

  logic            stall_o;
  logic [XLEN-1:0] alu_a_o;
  logic [XLEN-1:0] alu_b_o;
  logic [4:0]      alu_op_o;
  logic [XLEN-1:0] store_data_o;
  logic            ex_valid_o;
  logic            ex_regwrite_o;
  logic            ex_memread_o;
  logic            ex_memwrite_o;
  logic [4:0]      ex_rd_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [1:0]      ex_wdsel_o;

  modport master (
    output id_valid_i, id_pc_i, id_rd1_i, id_rd2_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_use_rs1_i, id_use_rs2_i, id_aluop_i, id_alusrc_a_i, id_alusrc_b_i,
           id_regwrite_i, id_memread_i, id_memwrite_i, id_wdsel_i, flush_i,
           exmem_regwrite_i, exmem_rd_i, exmem_result_i,
           memwb_regwrite_i, memwb_rd_i, memwb_result_i,
    input  stall_o, alu_a_o, alu_b_o, alu_op_o, store_data_o, ex_valid_o, ex_regwrite_o,
           ex_memread_o, ex_memwrite_o, ex_rd_o, ex_pc_o, ex_wdsel_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rd1_i, id_rd2_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_use_rs1_i, id_use_rs2_i, id_aluop_i, id_alusrc_a_i, id_alusrc_b_i,
           id_regwrite_i, id_memread_i, id_memwrite_i, id_wdsel_i, flush_i,
           exmem_regwrite_i, exmem_rd_i, exmem_result_i,
           memwb_regwrite_i, memwb_rd_i, memwb_result_i,
    output stall_o, alu_a_o, alu_b_o, alu_op_o, store_data_o, ex_valid_o, ex_regwrite_o,
           ex_memread_o, ex_memwrite_o, ex_rd_o, ex_pc_o, ex_wdsel_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling and
// EX/MEM, MEM/WB operand forwarding into the ALU.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rstn,
  id_ex_if.slave bus
);

  localparam logic [4:0] ALU_OP_ADD = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [4:0]      aluop;
    logic            alusrc_a;
    logic            alusrc_b;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic [1:0]      wdsel;
  } stage_t;

  localparam stage_t BUBBLE = stage_t'({1'b0, {(4*XLEN){1'b0}}, 15'd0, ALU_OP_ADD, 7'd0});

  // A writer hits a source register only if it writes, targets a non-zero rd, and matches.
  function automatic logic writes_reg(input logic regwrite, input logic [4:0] rd,
                                      input logic [4:0] src);
    return regwrite && (rd != 5'd0) && (rd == src);
  endfunction

  stage_t          stage_d, stage_q;
  logic            stall;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    stall = stage_q.valid && stage_q.memread && (stage_q.rd != 5'd0) && bus.id_valid_i &&
            ((bus.id_use_rs1_i && (stage_q.rd == bus.id_rs1_i)) ||
             (bus.id_use_rs2_i && (stage_q.rd == bus.id_rs2_i))) &&
            !bus.flush_i;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    stage_d = BUBBLE;
    if (!bus.flush_i && !stall) begin
      stage_d.valid    = bus.id_valid_i;
      stage_d.pc       = bus.id_pc_i;
      stage_d.rd1      = writes_reg(bus.memwb_regwrite_i, bus.memwb_rd_i, bus.id_rs1_i)
                         ? bus.memwb_result_i : bus.id_rd1_i;
      stage_d.rd2      = writes_reg(bus.memwb_regwrite_i, bus.memwb_rd_i, bus.id_rs2_i)
                         ? bus.memwb_result_i : bus.id_rd2_i;
      stage_d.imm      = bus.id_imm_i;
      stage_d.rs1      = bus.id_rs1_i;
      stage_d.rs2      = bus.id_rs2_i;
      stage_d.rd       = bus.id_rd_i;
      stage_d.aluop    = bus.id_aluop_i;
      stage_d.alusrc_a = bus.id_alusrc_a_i;
      stage_d.alusrc_b = bus.id_alusrc_b_i;
      stage_d.regwrite = bus.id_regwrite_i;
      stage_d.memread  = bus.id_memread_i;
      stage_d.memwrite = bus.id_memwrite_i;
      stage_d.wdsel    = bus.id_wdsel_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stage_q <= BUBBLE;
    else       stage_q <= stage_d;
  end

  // EX/MEM is the younger result, so it takes priority over MEM/WB.
  always_comb begin
    if (writes_reg(bus.exmem_regwrite_i, bus.exmem_rd_i, stage_q.rs1))      fwd_rs1 = bus.exmem_result_i;
    else if (writes_reg(bus.memwb_regwrite_i, bus.memwb_rd_i, stage_q.rs1)) fwd_rs1 = bus.memwb_result_i;
    else                                                                     fwd_rs1 = stage_q.rd1;
    if (writes_reg(bus.exmem_regwrite_i, bus.exmem_rd_i, stage_q.rs2))      fwd_rs2 = bus.exmem_result_i;
    else if (writes_reg(bus.memwb_regwrite_i, bus.memwb_rd_i, stage_q.rs2)) fwd_rs2 = bus.memwb_result_i;
    else                                                                     fwd_rs2 = stage_q.rd2;
  end

  always_comb begin
    bus.alu_a_o      = '0;
    bus.alu_b_o      = '0;
    bus.store_data_o = '0;
    bus.alu_op_o     = ALU_OP_ADD;
    if (stage_q.valid) begin
      bus.alu_a_o      = stage_q.alusrc_a ? stage_q.pc  : fwd_rs1;
      bus.alu_b_o      = stage_q.alusrc_b ? stage_q.imm : fwd_rs2;
      bus.store_data_o = fwd_rs2;
      bus.alu_op_o     = stage_q.aluop;
    end
  end

  assign bus.stall_o       = stall;
  assign bus.ex_valid_o    = stage_q.valid;
  assign bus.ex_regwrite_o = stage_q.regwrite;
  assign bus.ex_memread_o  = stage_q.memread;
  assign bus.ex_memwrite_o = stage_q.memwrite;
  assign bus.ex_rd_o       = stage_q.rd;
  assign bus.ex_pc_o       = stage_q.pc;
  assign bus.ex_wdsel_o    = stage_q.wdsel;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/forwarding scenarios plus randomized traffic
// checked against a behavioural model of the stage contents.
module tb_id_ex_stage;

  localparam logic [4:0] ALU_ADD = 5'd0;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_if #(.XLEN(32)) bus ();
  id_ex_stage #(.XLEN(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  task automatic set_id(input logic v, input logic [31:0] pc, rd1, rd2, imm,
                        input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                        input logic [4:0] op, input logic sa, sb, rw, mr, mw,
                        input logic [1:0] ws);
    bus.id_valid_i = v;   bus.id_pc_i = pc;     bus.id_rd1_i = rd1; bus.id_rd2_i = rd2;
    bus.id_imm_i = imm;   bus.id_rs1_i = rs1;   bus.id_rs2_i = rs2; bus.id_rd_i = rd;
    bus.id_use_rs1_i = u1; bus.id_use_rs2_i = u2; bus.id_aluop_i = op;
    bus.id_alusrc_a_i = sa; bus.id_alusrc_b_i = sb; bus.id_regwrite_i = rw;
    bus.id_memread_i = mr; bus.id_memwrite_i = mw; bus.id_wdsel_i = ws;
  endtask

  task automatic set_fwd(input logic exrw, input logic [4:0] exrd, input logic [31:0] exres,
                         input logic wbrw, input logic [4:0] wbrd, input logic [31:0] wbres);
    bus.exmem_regwrite_i = exrw; bus.exmem_rd_i = exrd; bus.exmem_result_i = exres;
    bus.memwb_regwrite_i = wbrw; bus.memwb_rd_i = wbrd; bus.memwb_result_i = wbres;
  endtask

  task automatic idle_all();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 2'd0);
    set_fwd(0, 0, 0, 0, 0, 0);
    bus.flush_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0 || bus.alu_op_o !== ALU_ADD || bus.alu_a_o !== 32'h0)
      begin errors++; $display("FAIL reset_hold: valid=%b op=%h a=%h want 0/00/0", bus.ex_valid_o, bus.alu_op_o, bus.alu_a_o); end
    rstn = 1'b1;
    // lw x7 with A=PC, B=imm so outputs are visibly non-zero before reset.
    set_id(1, 32'h100, 32'h11, 32'h99, 32'h44, 5'd2, 5'd3, 5'd7, 1, 0, 5'd3, 1, 1, 1, 1, 0, 2'd1);
    @(posedge clk);
    @(negedge clk);
    set_id(1, 32'h104, 0, 0, 0, 5'd7, 5'd1, 5'd8, 1, 1, 5'd0, 0, 0, 1, 0, 0, 2'd0);
    #1;
    checks++; if (bus.alu_a_o !== 32'h100) begin errors++; $display("FAIL reset_pre_a: got %h want %h", bus.alu_a_o, 32'h100); end
    checks++; if (bus.alu_op_o !== 5'd3) begin errors++; $display("FAIL reset_pre_op: got %h want %h", bus.alu_op_o, 5'd3); end
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL reset_pre_stall: got %b want 1", bus.stall_o); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 0 || bus.ex_regwrite_o !== 0 || bus.ex_memread_o !== 0 || bus.ex_memwrite_o !== 0)
      begin errors++; $display("FAIL reset_ctrl: v=%b rw=%b mr=%b mw=%b want 0", bus.ex_valid_o, bus.ex_regwrite_o, bus.ex_memread_o, bus.ex_memwrite_o); end
    checks++; if (bus.ex_rd_o !== 5'd0 || bus.ex_pc_o !== 32'h0 || bus.ex_wdsel_o !== 2'd0)
      begin errors++; $display("FAIL reset_fields: rd=%h pc=%h ws=%h want 0", bus.ex_rd_o, bus.ex_pc_o, bus.ex_wdsel_o); end
    checks++; if (bus.alu_a_o !== 0 || bus.alu_b_o !== 0 || bus.store_data_o !== 0)
      begin errors++; $display("FAIL reset_data: a=%h b=%h sd=%h want 0", bus.alu_a_o, bus.alu_b_o, bus.store_data_o); end
    checks++; if (bus.alu_op_o !== ALU_ADD) begin errors++; $display("FAIL reset_op: got %h want %h", bus.alu_op_o, ALU_ADD); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
    @(negedge clk);
    idle_all();
    rstn = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    idle_all();
    set_id(1, 32'h300, 32'h10, 32'h20, 0, 5'd3, 5'd4, 5'd5, 1, 1, ALU_ADD, 0, 0, 1, 0, 0, 2'd0);
    @(posedge clk);
    @(negedge clk);
    idle_all();
    set_fwd(1, 5'd3, 32'h55, 1, 5'd3, 32'h77);
    #1;
    checks++; if (bus.alu_a_o !== 32'h55) begin errors++; $display("FAIL prio_exmem: got %h want %h", bus.alu_a_o, 32'h55); end
    checks++; if (bus.alu_b_o !== 32'h20) begin errors++; $display("FAIL prio_b_unfwd: got %h want %h", bus.alu_b_o, 32'h20); end
    bus.exmem_regwrite_i = 1'b0;
    #1;
    checks++; if (bus.alu_a_o !== 32'h77) begin errors++; $display("FAIL prio_memwb: got %h want %h", bus.alu_a_o, 32'h77); end
    bus.memwb_regwrite_i = 1'b0;
    #1;
    checks++; if (bus.alu_a_o !== 32'h10) begin errors++; $display("FAIL prio_reg: got %h want %h", bus.alu_a_o, 32'h10); end
  endtask

  task automatic test_x0_guard();
    @(negedge clk);
    idle_all();
    set_id(1, 32'h400, 0, 0, 0, 5'd0, 5'd0, 5'd6, 1, 1, ALU_ADD, 0, 0, 1, 0, 0, 2'd0);
    set_fwd(0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    idle_all();
    set_fwd(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF);
    #1;
    checks++; if (bus.alu_a_o !== 32'h0) begin errors++; $display("FAIL x0_a: got %h want 0", bus.alu_a_o); end
    checks++; if (bus.store_data_o !== 32'h0) begin errors++; $display("FAIL x0_sd: got %h want 0", bus.store_data_o); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle_all();
    set_id(1, 32'h200, 0, 0, 32'h4, 5'd2, 5'd0, 5'd7, 1, 0, ALU_ADD, 0, 1, 1, 1, 0, 2'd1);
    @(posedge clk);
    @(negedge clk);
    set_id(1, 32'h204, 0, 32'h5, 0, 5'd7, 5'd1, 5'd8, 1, 1, ALU_ADD, 0, 0, 1, 0, 0, 2'd0);
    #1;
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", bus.stall_o); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %b want 0", bus.stall_o); end
    checks++; if (bus.ex_valid_o !== 1'b0 || bus.ex_regwrite_o !== 1'b0)
      begin errors++; $display("FAIL lu_bubble: v=%b rw=%b want 0/0", bus.ex_valid_o, bus.ex_regwrite_o); end
    @(posedge clk);
    @(negedge clk);
    idle_all();
    set_fwd(0, 0, 0, 1, 5'd7, 32'hABCD);
    #1;
    checks++; if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd8)
      begin errors++; $display("FAIL lu_enter: v=%b rd=%h want 1/08", bus.ex_valid_o, bus.ex_rd_o); end
    checks++; if (bus.alu_a_o !== 32'hABCD) begin errors++; $display("FAIL lu_fwd_a: got %h want %h", bus.alu_a_o, 32'hABCD); end
    checks++; if (bus.alu_b_o !== 32'h5) begin errors++; $display("FAIL lu_b: got %h want %h", bus.alu_b_o, 32'h5); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle_all();
    set_id(1, 32'h500, 0, 0, 32'h8, 5'd2, 5'd0, 5'd7, 1, 0, ALU_ADD, 0, 1, 1, 1, 0, 2'd1);
    @(posedge clk);
    @(negedge clk);
    set_id(1, 32'h504, 0, 0, 0, 5'd7, 5'd1, 5'd8, 1, 1, ALU_ADD, 0, 0, 1, 0, 0, 2'd0);
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_vs_stall: got %b want 0", bus.stall_o); end
    @(posedge clk);
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0 || bus.ex_regwrite_o !== 1'b0)
      begin errors++; $display("FAIL flush_bubble: v=%b rw=%b want 0/0", bus.ex_valid_o, bus.ex_regwrite_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle_all();
    set_id(1, 32'h600, 32'h1, 32'h2, 0, 5'd1, 5'd2, 5'd3, 1, 1, ALU_ADD, 0, 0, 1, 0, 0, 2'd0);
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_flush1: got %b want 0", bus.ex_valid_o); end
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_flush2: got %b want 0", bus.ex_valid_o); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.ex_valid_o !== 1'b1 || bus.ex_pc_o !== 32'h600)
      begin errors++; $display("FAIL b2b_resume: v=%b pc=%h want 1/600", bus.ex_valid_o, bus.ex_pc_o); end
  endtask

  task automatic test_capture_bypass();
    @(negedge clk);
    idle_all();
    set_id(1, 32'h700, 0, 0, 0, 5'd9, 5'd9, 5'd10, 1, 1, ALU_ADD, 0, 0, 1, 0, 0, 2'd0);
    set_fwd(0, 0, 0, 1, 5'd9, 32'h1234);
    @(posedge clk);
    @(negedge clk);
    idle_all();
    #1;
    checks++; if (bus.alu_a_o !== 32'h1234) begin errors++; $display("FAIL bypass_a: got %h want %h", bus.alu_a_o, 32'h1234); end
    checks++; if (bus.store_data_o !== 32'h1234) begin errors++; $display("FAIL bypass_sd: got %h want %h", bus.store_data_o, 32'h1234); end
  endtask

  // Reference model: what the EX slot holds, by architectural meaning.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd, op;
    logic        sa, sb, rw, mr, mw;
    logic [1:0]  ws;
  } ex_t;

  function automatic logic [31:0] forwarded(input logic [4:0] src, input logic [31:0] held);
    if (src == 0) return held;
    if (bus.exmem_regwrite_i && bus.exmem_rd_i == src) return bus.exmem_result_i;
    if (bus.memwb_regwrite_i && bus.memwb_rd_i == src) return bus.memwb_result_i;
    return held;
  endfunction

  task automatic test_random();
    ex_t m;
    logic exp_stall;
    logic [31:0] ea, eb, esd;
    logic [4:0] eop;
    @(negedge clk);
    idle_all();
    rstn = 1'b0;
    #1 rstn = 1'b1;
    m = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      set_id($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom), 2'($urandom));
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      bus.flush_i = ($urandom_range(0, 7) == 0);
      #1;
      exp_stall = m.valid && m.mr && m.rd != 0 && bus.id_valid_i && !bus.flush_i &&
                  ((bus.id_use_rs1_i && bus.id_rs1_i == m.rd) || (bus.id_use_rs2_i && bus.id_rs2_i == m.rd));
      ea = 0; eb = 0; esd = 0; eop = ALU_ADD;
      if (m.valid) begin
        ea  = m.sa ? m.pc  : forwarded(m.rs1, m.a);
        eb  = m.sb ? m.imm : forwarded(m.rs2, m.b);
        esd = forwarded(m.rs2, m.b);
        eop = m.op;
      end
      checks++; if (bus.stall_o !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, bus.stall_o, exp_stall); end
      checks++; if ({bus.ex_valid_o, bus.ex_regwrite_o, bus.ex_memread_o, bus.ex_memwrite_o} !== {m.valid, m.rw, m.mr, m.mw})
        begin errors++; $display("FAIL rnd_ctrl c%0d: got %b want %b", cyc,
          {bus.ex_valid_o, bus.ex_regwrite_o, bus.ex_memread_o, bus.ex_memwrite_o}, {m.valid, m.rw, m.mr, m.mw}); end
      checks++; if (bus.ex_pc_o !== m.pc || bus.ex_rd_o !== m.rd || bus.ex_wdsel_o !== m.ws)
        begin errors++; $display("FAIL rnd_fields c%0d: pc=%h rd=%h ws=%h want %h %h %h", cyc,
          bus.ex_pc_o, bus.ex_rd_o, bus.ex_wdsel_o, m.pc, m.rd, m.ws); end
      checks++; if (bus.alu_a_o !== ea) begin errors++; $display("FAIL rnd_a c%0d: got %h want %h", cyc, bus.alu_a_o, ea); end
      checks++; if (bus.alu_b_o !== eb) begin errors++; $display("FAIL rnd_b c%0d: got %h want %h", cyc, bus.alu_b_o, eb); end
      checks++; if (bus.store_data_o !== esd) begin errors++; $display("FAIL rnd_sd c%0d: got %h want %h", cyc, bus.store_data_o, esd); end
      checks++; if (bus.alu_op_o !== eop) begin errors++; $display("FAIL rnd_op c%0d: got %h want %h", cyc, bus.alu_op_o, eop); end
      if (bus.flush_i || exp_stall) begin
        m = '0;
      end else begin
        m.valid = bus.id_valid_i; m.pc = bus.id_pc_i; m.imm = bus.id_imm_i;
        m.rs1 = bus.id_rs1_i; m.rs2 = bus.id_rs2_i; m.rd = bus.id_rd_i; m.op = bus.id_aluop_i;
        m.sa = bus.id_alusrc_a_i; m.sb = bus.id_alusrc_b_i; m.rw = bus.id_regwrite_i;
        m.mr = bus.id_memread_i; m.mw = bus.id_memwrite_i; m.ws = bus.id_wdsel_i;
        // A register written back this cycle is read with its new value.
        m.a = (bus.memwb_regwrite_i && bus.memwb_rd_i != 0 && bus.memwb_rd_i == bus.id_rs1_i) ? bus.memwb_result_i : bus.id_rd1_i;
        m.b = (bus.memwb_regwrite_i && bus.memwb_rd_i != 0 && bus.memwb_rd_i == bus.id_rs2_i) ? bus.memwb_result_i : bus.id_rd2_i;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_x0_guard();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_capture_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
